// File: rtl/spi_regif.sv
// Register-access front end behind the SPI slave: decodes 16-bit frames into
// single-cycle register bus writes/reads and returns status plus read data on din.
module spi_regif #(
    parameter int unsigned     AW        = 7,
    parameter logic [AW-1:0]   CTRL_ADDR = 7'h7F,
    parameter logic [3:0]      SYNC      = 4'hA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          done,
    input  logic [15:0]   dout,
    output logic [15:0]   din,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic [7:0]    frame_cnt,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDCAP} state_e;

    state_e        state_q, state_d;
    logic          in_frame_q, in_frame_d;
    logic          ovf_q, ovf_d;
    logic          abort_q, abort_d;
    logic          rdvalid_q, rdvalid_d;
    logic [7:0]    rdbuf_q, rdbuf_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic          reg_re_q, reg_re_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          err_q, err_d;
    logic [15:0]   din_q, din_d;
    logic          frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_frame_q  <= 1'b0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            rdvalid_q   <= 1'b0;
            rdbuf_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            din_q       <= {SYNC, 12'h000};
        end else begin
            state_q     <= state_d;
            in_frame_q  <= in_frame_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
            rdvalid_q   <= rdvalid_d;
            rdbuf_q     <= rdbuf_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            din_q       <= din_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_frame_d  = in_frame_q;
        ovf_d       = ovf_q;
        abort_d     = abort_q;
        rdvalid_d   = rdvalid_q;
        rdbuf_d     = rdbuf_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        frame_ok    = done && in_frame_q;

        // A same-cycle done is decoded first, so start then re-arms without abort.
        if (start) begin
            in_frame_d = 1'b1;
        end else if (done) begin
            in_frame_d = 1'b0;
        end
        if (start && in_frame_q && !done) begin
            abort_d = 1'b1;
        end

        // Strobes are registered, so RDCAP spans two cycles: the reg_re cycle,
        // then the cycle in which reg_rdata is valid and gets captured.
        case (state_q)
            WR: begin
                reg_we_d = 1'b1;
                state_d  = IDLE;
            end
            RD: begin
                reg_re_d = 1'b1;
                state_d  = RDCAP;
            end
            RDCAP: begin
                if (!reg_re_q) begin
                    rdbuf_d   = reg_rdata;
                    rdvalid_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: ;
        endcase

        if (frame_ok) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (state_q == IDLE) begin
                reg_addr_d  = dout[14:8];
                reg_wdata_d = dout[7:0];
                if (dout[15]) begin
                    state_d = RD;
                end else begin
                    rdvalid_d = 1'b0;
                    if (dout[14:8] != CTRL_ADDR) begin
                        state_d = WR;
                    end else if (dout[0]) begin
                        ovf_d   = 1'b0;
                        abort_d = 1'b0;
                    end
                end
            end else begin
                ovf_d = 1'b1;
            end
        end

        din_d = {SYNC, ovf_q, abort_q, rdvalid_q, 1'b0, rdbuf_q};
        err_d = ovf_q | abort_q;
    end

    assign din       = din_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_regif.sv
// Scoreboard bench for spi_regif: expected bus operations are queued when a
// frame is driven and checked when the DUT strobes reg_we/reg_re.
module tb_spi_regif;

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [15:0] dout = '0;
    logic [15:0] din;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata = 8'hEE;
    logic [7:0]  frame_cnt;
    logic        err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned we_cnt = 0;
    int unsigned re_cnt = 0;
    op_t         exp_q[$];
    op_t         exp_op;
    op_t         got_op;
    logic [6:0]  rd_addr;

    spi_regif #(.AW(7), .CTRL_ADDR(7'h7F), .SYNC(4'hA)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .dout(dout),
        .din(din), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [6:0] a);
        return {1'b0, a} ^ 8'h5F;
    endfunction

    // Bus monitor: every strobe must match the oldest queued operation.
    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            if (reg_we) we_cnt++;
            if (reg_re) re_cnt++;
            vectors++;
            if (reg_we && reg_re) begin
                miscompares++;
                $display("FAIL strobe_overlap we=%0b re=%0b required exactly one", reg_we, reg_re);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe we=%0b re=%0b addr=%h wdata=%h required none",
                         reg_we, reg_re, reg_addr, reg_wdata);
            end else begin
                exp_op = exp_q.pop_front();
                got_op = {reg_re, reg_addr, reg_wdata};
                if (got_op !== exp_op) begin
                    miscompares++;
                    $display("FAIL bus_op got rd=%0b addr=%h wdata=%h required rd=%0b addr=%h wdata=%h",
                             got_op.rd, got_op.addr, got_op.wdata, exp_op.rd, exp_op.addr, exp_op.wdata);
                end
            end
        end
    end

    // Register file model: read data is valid only in the cycle after reg_re.
    always @(negedge clk) begin
        if (reg_re) begin
            rd_addr = reg_addr;
            @(posedge clk); #1;
            reg_rdata = mem_val(rd_addr);
            @(posedge clk); #1;
            reg_rdata = 8'hEE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [15:0] f);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        dout = f; done = 1'b1; tick(); done = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; repeat (3) tick(); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (reg_we !== 1'b0 || reg_re !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle_strobe we=%0b re=%0b required 0/0", reg_we, reg_re);
            end
        end
        vectors++;
        if (din !== 16'hA000) begin miscompares++; $display("FAIL reset_din got %h required a000", din); end
        vectors++;
        if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt got %0d required 0", frame_cnt); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b required 0", err); end
        vectors++;
        if (reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_bus got addr=%h wdata=%h required 00/00", reg_addr, reg_wdata);
        end
    endtask

    task automatic test_write();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        exp_q.push_back(op_t'{1'b0, 7'h12, 8'h34});
        dout = 16'h1234; done = 1'b1; tick(); done = 1'b0;
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL write_early got we=%0b required 0", reg_we); end
        tick();
        vectors++;
        if (reg_we !== 1'b1) begin miscompares++; $display("FAIL write_latency got we=%0b required 1", reg_we); end
        tick();
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL write_width got we=%0b required 0", reg_we); end
        vectors++;
        if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL write_frame_cnt got %0d required 1", frame_cnt); end
        repeat (3) tick();
        vectors++;
        if (din !== 16'hA000) begin miscompares++; $display("FAIL write_din got %h required a000", din); end
    endtask

    task automatic test_read();
        exp_q.push_back(op_t'{1'b1, 7'h05, 8'h00});
        send_frame(16'h8500);
        vectors++;
        if (din !== 16'hA25A) begin miscompares++; $display("FAIL read_din got %h required a25a", din); end
        vectors++;
        if (frame_cnt !== 8'd2) begin miscompares++; $display("FAIL read_frame_cnt got %0d required 2", frame_cnt); end
    endtask

    task automatic test_abort();
        int unsigned we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        vectors++;
        if (din !== 16'hA65A) begin miscompares++; $display("FAIL abort_din got %h required a65a", din); end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL abort_err got %0b required 1", err); end
        dout = 16'h7F01; done = 1'b1; tick(); done = 1'b0;
        repeat (6) tick();
        vectors++;
        if (din !== 16'hA05A) begin miscompares++; $display("FAIL ctrl_clear_din got %h required a05a", din); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL ctrl_clear_err got %0b required 0", err); end
        vectors++;
        if (frame_cnt !== 8'd3) begin miscompares++; $display("FAIL ctrl_frame_cnt got %0d required 3", frame_cnt); end
        vectors++;
        if (we_cnt !== we0 || re_cnt !== re0) begin
            miscompares++;
            $display("FAIL abort_no_strobe got we=%0d re=%0d required we=%0d re=%0d", we_cnt, re_cnt, we0, re0);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned we0, re0;
        logic [7:0]  cnt0;
        we0 = we_cnt; re0 = re_cnt; cnt0 = frame_cnt;
        exp_q.push_back(op_t'{1'b1, 7'h10, 8'h00});
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1; done = 1'b1; dout = 16'h9000; tick();
        start = 1'b0; dout = 16'h1111; tick();
        done = 1'b0;
        repeat (8) tick();
        vectors++;
        if (din !== 16'hAA4F) begin miscompares++; $display("FAIL ovf_din got %h required aa4f", din); end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_err got %0b required 1", err); end
        vectors++;
        if (frame_cnt !== cnt0 + 8'd2) begin
            miscompares++;
            $display("FAIL ovf_frame_cnt got %0d required %0d", frame_cnt, cnt0 + 8'd2);
        end
        vectors++;
        if (we_cnt !== we0 || re_cnt !== re0 + 1) begin
            miscompares++;
            $display("FAIL ovf_strobes got we=%0d re=%0d required we=%0d re=%0d", we_cnt, re_cnt, we0, re0 + 1);
        end
        send_frame(16'h7F01);
        vectors++;
        if (din !== 16'hA04F || err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got din=%h err=%0b required a04f/0", din, err);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] a;
        logic [7:0] d;
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < 256; i++) begin
            a = 7'(i);
            if (a == 7'h7F) a = 7'h00;
            d = 8'($urandom);
            exp_q.push_back(op_t'{1'b0, a, d});
            send_frame({1'b0, a, d});
            if (i == 254) begin
                vectors++;
                if (frame_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL wrap_255 got %0d required 255", frame_cnt);
                end
            end
        end
        vectors++;
        if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_zero got %0d required 0", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        exp_q.push_back(op_t'{1'b0, 7'h22, 8'h33});
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        dout = 16'h2233; done = 1'b1; tick(); done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (reg_we === 1'b1) seen = 1'b1;
            else tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL reset_mid_wait got no reg_we required one within 6 cycles"); end
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (reg_we !== 1'b0 || reg_re !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_we got we=%0b re=%0b required 0/0", reg_we, reg_re);
            end
            tick();
        end
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        dout = 16'h8A00; done = 1'b1; tick(); done = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (reg_re !== 1'b0 || reg_we !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_re got we=%0b re=%0b required 0/0", reg_we, reg_re);
            end
            tick();
        end
        vectors++;
        if (din !== 16'hA000 || frame_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_state got din=%h cnt=%0d required a000/0", din, frame_cnt);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        repeat (4) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
